// File: rtl/irq_request_collector_pkg.sv
// Shared definitions for the interrupt request collector and the priority
// encoder that consumes its request vector.
//   IRQ_N / IRQ_IDX_W : interrupt line count and matching index width
//   irq_state_e       : request/acknowledge/EOI state encoding
package irq_request_collector_pkg;
  localparam int IRQ_N     = 8;
  localparam int IRQ_IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;
endpackage

// File: rtl/irq_request_collector_if.sv
// Bus between the collector and its environment (interrupt sources, encoder
// and consumer).
//   irq_in/edge_sel/mask : raw lines, trigger mode, request suppression
//   req_vec              : masked pending vector to the encoder
//   irq_out/in_service   : request line and one-hot in-service bit
//   ack_valid/ack_idx/eoi: consumer acknowledge and end-of-interrupt
// slave = collector side, master = environment side.
interface irq_request_collector_if
  import irq_request_collector_pkg::*;
#(
  parameter int N     = IRQ_N,
  parameter int IDX_W = IRQ_IDX_W
);
  logic [N-1:0]     irq_in;
  logic [N-1:0]     edge_sel;
  logic [N-1:0]     mask;
  logic [N-1:0]     req_vec;
  logic             irq_out;
  logic             ack_valid;
  logic [IDX_W-1:0] ack_idx;
  logic             eoi;
  logic [N-1:0]     in_service;

  modport slave (
    input  irq_in, edge_sel, mask, ack_valid, ack_idx, eoi,
    output req_vec, irq_out, in_service
  );
  modport master (
    output irq_in, edge_sel, mask, ack_valid, ack_idx, eoi,
    input  req_vec, irq_out, in_service
  );
endinterface

// File: rtl/irq_request_collector_sync.sv
// Per-line synchroniser plus rising-edge detector.
//   clk, rst_n : clock, async active-low reset
//   d_i        : raw asynchronous line
//   s_o        : synchronised level
//   rise_o     : one-cycle pulse when s_o goes 0 -> 1
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic s_o,
  output logic rise_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sd_q;

  // sd_q resets high: a line already high when reset releases is a level,
  // not a new edge, so it must not raise a request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      sd_q   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      sd_q   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~sd_q;
endmodule

// File: rtl/irq_request_collector.sv
// Interrupt request collector: synchronises raw lines, holds edge/level
// pending bits, masks them into req_vec for the priority encoder and runs the
// request -> acknowledge -> end-of-interrupt handshake with the consumer.
//   clk, rst_n : clock, async active-low reset
//   bus        : collector side of irq_request_collector_if
module irq_request_collector
  import irq_request_collector_pkg::*;
#(
  parameter int N           = IRQ_N,
  parameter int IDX_W       = IRQ_IDX_W,
  parameter int SYNC_STAGES = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  irq_request_collector_if.slave  bus
);
  logic [N-1:0] s, rise;
  logic [N-1:0] pend_q, pend_d, req_q;
  logic [N-1:0] in_service_q, in_service_d;
  logic [N-1:0] ack_oh, clr;
  logic         irq_out_q, irq_out_d;
  logic         ack_ok;
  irq_state_e   state_q, state_d;

  for (genvar g = 0; g < N; g++) begin : g_line
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (bus.irq_in[g]),
      .s_o    (s[g]),
      .rise_o (rise[g])
    );
  end

  assign ack_oh = {{(N-1){1'b0}}, 1'b1} << bus.ack_idx;
  // Only an ack for a line actually being requested is honoured.
  assign ack_ok = (state_q == ST_ACTIVE) & bus.ack_valid & req_q[bus.ack_idx];
  assign clr    = ack_ok ? ack_oh : '0;

  // Edge lines: a fresh rise wins over a same-cycle clear.
  // Level lines: follow the synchronised level, ack has no effect.
  assign pend_d = (bus.edge_sel & (rise | (pend_q & ~clr))) | (~bus.edge_sel & s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      req_q  <= '0;
    end else begin
      pend_q <= pend_d;
      req_q  <= pend_q & ~bus.mask;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      irq_out_q    <= 1'b0;
      in_service_q <= '0;
    end else begin
      state_q      <= state_d;
      irq_out_q    <= irq_out_d;
      in_service_q <= in_service_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (|req_q) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (!(|req_q))  state_d = ST_IDLE;
        else if (ack_ok) state_d = ST_SERVICE;
      end
      ST_SERVICE: if (bus.eoi) state_d = (|req_q) ? ST_ACTIVE : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs, registered alongside the state
  always_comb begin
    irq_out_d    = (state_d == ST_ACTIVE);
    in_service_d = in_service_q;
    if (ack_ok)
      in_service_d = ack_oh;
    else if ((state_q == ST_SERVICE) && bus.eoi)
      in_service_d = '0;
  end

  assign bus.req_vec    = req_q;
  assign bus.irq_out    = irq_out_q;
  assign bus.in_service = in_service_q;
endmodule

// File: tb/tb_irq_request_collector.sv
module tb_irq_request_collector;
  localparam int SYNC = 2;
  localparam int M_IDLE = 0, M_ACT = 1, M_SVC = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  irq_request_collector_if #(.N(8), .IDX_W(3)) bus ();

  irq_request_collector #(.N(8), .IDX_W(3), .SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] req;
    logic       irq;
    logic [7:0] ins;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: values visible after each clock edge.
  logic [7:0] dly[$];   // synchroniser as a plain delay line
  logic [7:0] m_s, m_prev, m_pend, m_req, m_ins;
  int         m_st;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    dly.delete();
    for (int i = 0; i < SYNC - 1; i++) dly.push_back(8'h00);
    m_s = 8'h00; m_prev = 8'hFF;  // a line high out of reset is not an edge
    m_pend = 8'h00; m_req = 8'h00; m_ins = 8'h00; m_st = M_IDLE;
  endtask

  task automatic model_step(input logic [7:0] irq, input logic [7:0] es,
                            input logic [7:0] msk, input logic av,
                            input logic [2:0] ai, input logic eo);
    logic [7:0] np, nr;
    bit         acc;
    int         nst;
    exp_t       e;
    acc = (m_st == M_ACT) && av && m_req[ai];
    for (int i = 0; i < 8; i++) begin
      if (!es[i])                        np[i] = m_s[i];
      else if (m_s[i] && !m_prev[i])     np[i] = 1'b1;   // new edge never lost
      else if (acc && (int'(ai) == i))   np[i] = 1'b0;
      else                               np[i] = m_pend[i];
    end
    nr  = m_pend & ~msk;
    nst = m_st;
    if (m_st == M_IDLE && m_req != 0) nst = M_ACT;
    else if (m_st == M_ACT) begin
      if (m_req == 0) nst = M_IDLE;
      else if (acc)   nst = M_SVC;
    end else if (m_st == M_SVC && eo) nst = (m_req != 0) ? M_ACT : M_IDLE;
    if (acc) m_ins = 8'(1 << ai);
    else if (m_st == M_SVC && eo) m_ins = 8'h00;
    m_prev = m_s;
    dly.push_back(irq);
    m_s    = dly.pop_front();
    m_pend = np;
    m_req  = nr;
    m_st   = nst;
    e.req = m_req; e.irq = (m_st == M_ACT); e.ins = m_ins;
    sb.push_back(e);
  endtask

  // Monitor: compare every cycle for which the model produced a prediction.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("req_vec", bus.req_vec, e.req);
      chk("irq_out", {7'd0, bus.irq_out}, {7'd0, e.irq});
      chk("in_service", bus.in_service, e.ins);
    end
  end

  task automatic drive(input logic [7:0] irq, input logic [7:0] es,
                       input logic [7:0] msk, input logic av,
                       input logic [2:0] ai, input logic eo);
    bus.irq_in = irq; bus.edge_sel = es; bus.mask = msk;
    bus.ack_valid = av; bus.ack_idx = ai; bus.eoi = eo;
    model_step(irq, es, msk, av, ai, eo);
    @(negedge clk); #1;
  endtask

  logic [7:0] irq_v, es_v, msk_v;
  logic [2:0] ai_v;
  logic       av_v, eo_v;

  task automatic rand_cycle(input bit allow_eoi);
    irq_v = irq_v ^ 8'($urandom & $urandom & $urandom);
    if ($urandom_range(0, 19) == 0) msk_v = 8'($urandom & $urandom);
    av_v = ($urandom_range(0, 2) == 0);
    ai_v = 3'($urandom_range(0, 7));
    if (m_req != 0 && $urandom_range(0, 3) != 0)
      for (int t = 0; t < 16; t++) begin
        ai_v = 3'($urandom_range(0, 7));
        if (m_req[ai_v]) break;
      end
    eo_v = allow_eoi && ($urandom_range(0, 2) == 0);
    drive(irq_v, es_v, msk_v, av_v, ai_v, eo_v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.irq_in = 8'hFF; bus.edge_sel = 8'hFF; bus.mask = 8'h00;
    bus.ack_valid = 1'b0; bus.ack_idx = 3'd0; bus.eoi = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_vec", bus.req_vec, 8'h00);
    chk("reset_irq_out", {7'd0, bus.irq_out}, 8'h00);
    chk("reset_in_service", bus.in_service, 8'h00);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Lines static high in edge mode: no requests expected.
    irq_v = 8'hFF; es_v = 8'hFF; msk_v = 8'h00;
    repeat (8) drive(irq_v, es_v, msk_v, 1'b0, 3'd0, 1'b0);

    // Random traffic; first stretch edge-only, then mixed trigger modes.
    for (int c = 0; c < 3000; c++) begin
      if (c > 0 && c % 500 == 0) es_v = 8'($urandom);
      rand_cycle(1'b1);
    end

    // Reach SERVICE, then pull reset asynchronously mid-cycle.
    es_v = 8'hFF;
    begin
      bit got = 0;
      for (int c = 0; c < 400 && !got; c++) begin
        rand_cycle(1'b0);
        got = (m_st == M_SVC);
      end
      if (!got) begin
        errors++;
        $display("FAIL reach_service actual=not_reached expected=SERVICE");
      end
    end
    chk("pre_reset_in_service", bus.in_service, m_ins);
    rst_n = 1'b0;
    #1;
    chk("async_reset_req_vec", bus.req_vec, 8'h00);
    chk("async_reset_irq_out", {7'd0, bus.irq_out}, 8'h00);
    chk("async_reset_in_service", bus.in_service, 8'h00);
    @(negedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 200; c++) rand_cycle(1'b1);

    @(negedge clk); #1;
    chk("scoreboard_drained", 8'(sb.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
